wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 in_valid  input  1  producer offers a register result this cycle.
REQ-005 in_ready  output  1  queue accepts the offered result this cycle.
REQ-006 in_reg  input  5  destination register number of the offered result.
REQ-007 in_data  input  32  value of the offered result.
REQ-008 writeReg  output  5  register-file write address (head entry).
REQ-009 writeData  output  32  register-file write data (head entry).
REQ-010 enable  output  1  register-file write strobe; the head entry is committed on this posedge.
REQ-011 readReg1, readReg2  input  5 each  register numbers being read by decode this cycle.
REQ-012 byp1_hit, byp2_hit  output  1 each  a pending entry matches readReg1 / readReg2.
REQ-013 byp1_data, byp2_data  output  32 each  newest pending value for readReg1 / readReg2.
REQ-014 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-015 full, empty  output  1 each  count==DEPTH / count==0.

Function
REQ-016 Storage: circular buffer of DEPTH entries {reg[4:0], data[31:0]}; head pointer, tail pointer, and count are registered.
REQ-017 in_ready SHALL be !full && !rst (combinational); no same-cycle pass-through when full.
REQ-018 Push: on posedge with in_valid && in_ready && in_reg!=0, write the entry at tail, then tail+1 mod DEPTH.
REQ-019 Push with in_reg==0 SHALL be accepted (handshake completes) and discarded: no entry, count unchanged.
REQ-020 Drain: enable = !empty && !rst; writeReg/writeData = head entry, combinational from the registered head.
REQ-021 Pop: on every posedge with enable=1, head+1 mod DEPTH; exactly one commit per cycle, in FIFO order.
REQ-022 When empty: enable=0, writeReg=0, writeData=0.
REQ-023 Simultaneous push and pop: both pointers advance and count is unchanged; a push into an empty queue is visible on enable in the next cycle (1-cycle minimum latency).
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; count never exceeds DEPTH or underflows.
REQ-025 Bypass: for each read port, search the occupied entries, including the head being committed this cycle; hit=1 if any reg matches; data = the newest (closest to tail) matching entry.
REQ-026 Bypass for readReg==0 SHALL give hit=0 and data=0; on a miss, data=0.
REQ-027 Bypass SHALL NOT include the in_* entry being pushed in the same cycle.
REQ-028 Bypass outputs are combinational from registered state and read addresses only.

Reset
REQ-029 On a posedge with rst=1: head=tail=0, count=0; entry contents are don't-care.
REQ-030 While rst=1: in_ready=0, enable=0, byp*_hit=0, empty=1, full=0.
REQ-031 Reset mid-operation discards all pending entries without committing them; the cycle after rst falls behaves as empty.

Verification
REQ-032 Reset, then push {r5, 0x0000_00AA} -> next cycle enable=1, writeReg=5, writeData=0xAA; the following cycle empty=1.
REQ-033 Push r3=0x11, then r3=0x22, then r7=0x33 back-to-back, with readReg1=3 and readReg2=7 while all three are pending -> byp1_data=0x22, byp2_data=0x33, both hits=1; commits occur in order 0x11, 0x22, 0x33.
REQ-034 DEPTH=4: push on every cycle into an empty queue -> pop and push overlap each cycle, count stays at 1, and pointers wrap past 3 without loss over 10 pushes; commit values match push order.
REQ-035 Fill with DEPTH=4, with the register file held in reset until full -> full=1, in_ready=0, and a 5th in_valid is not accepted; it completes once the pop frees an entry.
REQ-036 Push {r0, 0xDEAD} -> in_ready=1 and the handshake completes, count stays 0, enable stays 0; readReg1=0 gives byp1_hit=0.
REQ-037 With 3 entries pending, assert rst for one cycle -> no enable pulse during rst; afterwards count=0, empty=1, byp hits=0.

Note on REQ-035: enable has no backpressure, so the queue can only fill if pushes outpace pops. The bench SHALL reach full by pushing while drain is blocked through bench-only force, or by using DEPTH=2 with pushes every cycle starting from 1 pending entry and an injected no-pop cycle.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: write-back queue that buffers register results and commits one
// per cycle (head first) into the register file. Decode can read any pending
// value through two bypass ports that return the newest matching entry.
//
// Handshake: a result moves from producer to queue on a rising edge where
// in_valid && in_ready are both 1. in_ready does not depend on in_valid.
// Once the producer raises in_valid it holds in_reg/in_data steady until
// that edge. A result for r0 completes the handshake but is dropped.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [31:0]              in_data,
  output logic [4:0]               writeReg,
  output logic [31:0]              writeData,
  output logic                     enable,
  input  logic [4:0]               readReg1,
  input  logic [4:0]               readReg2,
  output logic                     byp1_hit,
  output logic                     byp2_hit,
  output logic [31:0]              byp1_data,
  output logic [31:0]              byp2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    reg_mem_q  [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // Status flags read as an empty, non-accepting queue while reset is held.
  assign full     = (count_q == CW'(DEPTH)) && !rst;
  assign empty    = (count_q == '0) || rst;
  assign in_ready = !full && !rst;
  assign enable   = !empty;
  // Draining has no backpressure: every cycle the strobe is up, the head leaves.
  assign pop      = enable;
  assign push     = in_valid && in_ready && (in_reg != 5'd0);
  assign count    = count_q;

  assign writeReg  = empty ? 5'd0  : reg_mem_q[head_q];
  assign writeData = empty ? 32'd0 : data_mem_q[head_q];

  // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem_q[tail_q]  <= in_reg;
      data_mem_q[tail_q] <= in_data;
    end
  end

  // Bypass search from oldest to newest so the newest match wins.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = 32'd0;
    byp2_hit  = 1'b0;
    byp2_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (CW'(i) < count_q)) begin
        if ((readReg1 != 5'd0) && (reg_mem_q[head_q + AW'(i)] == readReg1)) begin
          byp1_hit  = 1'b1;
          byp1_data = data_mem_q[head_q + AW'(i)];
        end
        if ((readReg2 != 5'd0) && (reg_mem_q[head_q + AW'(i)] == readReg2)) begin
          byp2_hit  = 1'b1;
          byp2_data = data_mem_q[head_q + AW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus for wb_queue with a commit scoreboard.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        enable;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        byp1_hit;
  logic        byp2_hit;
  logic [31:0] byp1_data;
  logic [31:0] byp2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];

  wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .writeReg  (writeReg),
    .writeData (writeData),
    .enable    (enable),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp1_data (byp1_data),
    .byp2_data (byp2_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Commit monitor: each enable pulse must retire the oldest expected entry.
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL commit_unexpected: got reg=%0d data=%0h expected no commit", writeReg, writeData);
      end else begin
        check("commit", {writeReg, writeData}, exp_q.pop_front());
      end
    end else if (empty === 1'b1) begin
      check("idle_write_zero", {writeReg, writeData}, 37'd0);
    end
  end

  // Driver: offer one result and hold it until accepted (bounded wait).
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", {36'd0, in_ready}, 37'd1);
    if (r != 5'd0) exp_q.push_back({r, d});
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_reg   = 5'd0;
    in_data  = 32'd0;
    readReg1 = 5'd5;
    readReg2 = 5'd0;
    step();
    step();

    // Reset state while rst is held
    @(negedge clk);
    check("rst_in_ready", {36'd0, in_ready}, 37'd0);
    check("rst_enable",   {36'd0, enable},   37'd0);
    check("rst_empty",    {36'd0, empty},    37'd1);
    check("rst_full",     {36'd0, full},     37'd0);
    check("rst_byp1_hit", {36'd0, byp1_hit}, 37'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count",    {34'd0, count},    37'd0);
    check("post_rst_in_ready", {36'd0, in_ready}, 37'd1);
    step();

    // Single push: committed the next cycle, then empty
    push(5'd5, 32'h0000_00AA);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_enable", {36'd0, enable}, 37'd1);
    check("single_write",  {writeReg, writeData}, {5'd5, 32'h0000_00AA});
    check("single_count",  {34'd0, count}, 37'd1);
    step();
    @(negedge clk);
    check("single_empty_after", {36'd0, empty}, 37'd1);
    step();

    // Three pending entries, bypass returns newest value per register
    force dut.enable = 1'b0;
    push(5'd3, 32'h11);
    push(5'd3, 32'h22);
    push(5'd7, 32'h33);
    in_valid = 1'b0;
    readReg1 = 5'd3;
    readReg2 = 5'd7;
    @(negedge clk);
    check("byp3_count", {34'd0, count}, 37'd3);
    check("byp3_r1", {byp1_hit, byp1_data}, {5'd0, 1'b1, 32'h22});
    check("byp3_r2", {byp2_hit, byp2_data}, {5'd0, 1'b1, 32'h33});
    step();
    release dut.enable;
    step();
    step();
    @(negedge clk);
    check("byp1_head_count", {34'd0, count}, 37'd1);
    check("byp1_miss",       {byp1_hit, byp1_data}, 37'd0);
    check("byp2_head_hit",   {byp2_hit, byp2_data}, {5'd0, 1'b1, 32'h33});
    step();
    step();
    readReg1 = 5'd0;
    readReg2 = 5'd0;

    // Streaming: push every cycle, count settles at 1, pointers wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_reg   = 5'(i + 1);
      in_data  = 32'h100 + 32'(i);
      @(negedge clk);
      check("stream_count", {34'd0, count}, (i == 0) ? 37'd0 : 37'd1);
      check("stream_ready", {36'd0, in_ready}, 37'd1);
      exp_q.push_back({in_reg, in_data});
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_tail_count", {34'd0, count}, 37'd1);
    step();
    step();
    @(negedge clk);
    check("stream_drained", {36'd0, empty}, 37'd1);
    step();

    // Fill with drain blocked; fifth offer waits for a free entry
    force dut.enable = 1'b0;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    push(5'd13, 32'hA3);
    in_valid = 1'b1;
    in_reg   = 5'd14;
    in_data  = 32'h55;
    @(negedge clk);
    check("fill_full",     {36'd0, full},     37'd1);
    check("fill_in_ready", {36'd0, in_ready}, 37'd0);
    check("fill_count",    {34'd0, count},    37'd4);
    step();
    @(negedge clk);
    check("fill_hold_count", {34'd0, count}, 37'd4);
    step();
    release dut.enable;
    push(5'd14, 32'h55);
    in_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("fill_drained", {36'd0, empty}, 37'd1);
    step();

    // r0 push is accepted and dropped; in-flight push is not bypassed
    in_valid = 1'b1;
    in_reg   = 5'd0;
    in_data  = 32'hDEAD;
    readReg1 = 5'd0;
    @(negedge clk);
    check("r0_in_ready", {36'd0, in_ready}, 37'd1);
    check("r0_byp1_hit", {36'd0, byp1_hit}, 37'd0);
    step();
    in_reg   = 5'd9;
    in_data  = 32'h99;
    readReg2 = 5'd9;
    @(negedge clk);
    check("r0_count",  {34'd0, count},  37'd0);
    check("r0_enable", {36'd0, enable}, 37'd0);
    check("inflight_no_bypass", {byp2_hit, byp2_data}, 37'd0);
    exp_q.push_back({5'd9, 32'h99});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pending_bypass", {byp2_hit, byp2_data}, {5'd0, 1'b1, 32'h99});
    step();
    step();
    readReg2 = 5'd0;

    // Reset with three pending entries discards them
    force dut.enable = 1'b0;
    push(5'd1, 32'hC1);
    push(5'd2, 32'hC2);
    push(5'd3, 32'hC3);
    in_valid = 1'b0;
    readReg1 = 5'd1;
    readReg2 = 5'd2;
    release dut.enable;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_enable",   {36'd0, enable},   37'd0);
    check("midrst_in_ready", {36'd0, in_ready}, 37'd0);
    check("midrst_byp",      {35'd0, byp1_hit, byp2_hit}, 37'd0);
    check("midrst_flags",    {35'd0, empty, full}, 37'd2);
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("postrst_count",  {34'd0, count}, 37'd0);
    check("postrst_empty",  {36'd0, empty}, 37'd1);
    check("postrst_byp",    {35'd0, byp1_hit, byp2_hit}, 37'd0);
    check("postrst_enable", {36'd0, enable}, 37'd0);
    repeat (3) step();

    check("scoreboard_empty", 37'(exp_q.size()), 37'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
